// File: rtl/mfcc_melbank_sched_if.sv
// Bus bundle for the mel-filterbank sequencer:
// power-bin input stream, weight-ROM port and filter-energy output stream.
interface mfcc_melbank_sched_if #(
    parameter int ADDR_W = 9,
    parameter int PW     = 32,
    parameter int WW     = 16,
    parameter int FW     = 6,
    parameter int ACC_W  = 48
);
    logic              s_valid;
    logic              s_ready;
    logic [PW-1:0]     s_data;
    logic              s_last;
    logic [ADDR_W-1:0] rom_addr;
    logic [FW+WW-1:0]  rom_data;
    logic              m_valid;
    logic              m_ready;
    logic [ACC_W-1:0]  m_data;
    logic [FW-1:0]     m_idx;
    logic              m_last;

    modport master (
        input  s_valid, s_data, s_last, rom_data, m_ready,
        output s_ready, rom_addr, m_valid, m_data, m_idx, m_last
    );

    modport slave (
        output s_valid, s_data, s_last, rom_data, m_ready,
        input  s_ready, rom_addr, m_valid, m_data, m_idx, m_last
    );
endinterface

// File: rtl/mfcc_melbank_sched.sv
// Mel-filterbank sequencer: walks a frame of power bins through the weight ROM
// and accumulates rising/falling filter edges, emitting each finished filter.
module mfcc_melbank_sched #(
    parameter int NBINS   = 257,
    parameter int ADDR_W  = 9,
    parameter int PW      = 32,
    parameter int WW      = 16,
    parameter int FW      = 6,
    parameter int NFILT   = 40,
    parameter int ACC_W   = 48,
    parameter int ROM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mfcc_melbank_sched_if.master bus,
    output logic                 busy
);
    localparam int PRW = PW + WW + 1;
    localparam int SW  = ((ACC_W > PRW) ? ACC_W : PRW) + 1;
    localparam logic [FW-1:0]    NF   = FW'(NFILT);
    localparam logic [ACC_W-1:0] AMAX = '1;

    typedef enum logic [2:0] {IDLE, ROMW, STEP, EMIT, MAC, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] bin_q, bin_d;
    logic [FW-1:0]     cur_q, cur_d, f_q, f_d;
    logic [WW-1:0]     w_q, w_d;
    logic [PW-1:0]     p_q, p_d;
    logic              last_q, last_d, ret_q, ret_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic [ACC_W-1:0]  rise_q, rise_d, fall_q, fall_d;
    logic [FW-1:0]     rf, fcl;
    logic [WW:0]       wc;
    logic [PRW-1:0]    prod_r, prod_f;
    logic              shift, emit;

    function automatic logic [ACC_W-1:0] sat_add(
        input logic [ACC_W-1:0] a,
        input logic [PRW-1:0]   b
    );
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        return (s > SW'(AMAX)) ? AMAX : s[ACC_W-1:0];
    endfunction

    // ROM field split with filter clamp, and the two edge products
    always_comb begin
        rf     = bus.rom_data[FW+WW-1:WW];
        fcl    = (rf > NF) ? NF : rf;
        wc     = {1'b1, {WW{1'b0}}} - {1'b0, w_q};
        prod_r = PRW'(p_q) * PRW'(w_q);
        prod_f = PRW'(p_q) * PRW'(wc);
    end

    // Output ports decoded from state; data fields are zero outside EMIT
    always_comb begin
        emit         = (state_q == EMIT);
        bus.s_ready  = rst_n && (state_q == IDLE);
        bus.rom_addr = bin_q;
        bus.m_valid  = emit;
        bus.m_data   = emit ? fall_q : '0;
        bus.m_idx    = emit ? cur_q - FW'(1) : '0;
        bus.m_last   = emit && (cur_q == NF);
        busy         = (state_q != IDLE);
    end

    // Next-state, MAC and accumulator-shift logic
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        cur_d   = cur_q;
        f_d     = f_q;
        w_d     = w_q;
        p_d     = p_q;
        last_d  = last_q;
        ret_d   = ret_q;
        wcnt_d  = wcnt_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.s_valid) begin
                    p_d    = bus.s_data;
                    last_d = bus.s_last || (bin_q == ADDR_W'(NBINS - 1));
                    wcnt_d = '0;
                    if (ROM_LAT == 0) begin
                        f_d     = fcl;
                        w_d     = bus.rom_data[WW-1:0];
                        state_d = STEP;
                    end else begin
                        state_d = ROMW;
                    end
                end
            end
            ROMW: begin
                if (wcnt_q == 8'(ROM_LAT - 1)) begin
                    f_d     = fcl;
                    w_d     = bus.rom_data[WW-1:0];
                    state_d = STEP;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            STEP: begin
                // f below cur_f is a ROM error; it is absorbed like f == cur_f
                if (f_q <= cur_q) begin
                    state_d = MAC;
                end else if (cur_q == '0) begin
                    shift = 1'b1;
                end else begin
                    ret_d   = 1'b0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (bus.m_ready) begin
                    shift   = 1'b1;
                    state_d = ret_q ? FLUSH : STEP;
                end
            end
            MAC: begin
                if (cur_q < NF) rise_d = sat_add(rise_q, prod_r);
                if (cur_q != '0) fall_d = sat_add(fall_q, prod_f);
                bin_d   = bin_q + ADDR_W'(1);
                state_d = last_q ? FLUSH : IDLE;
            end
            FLUSH: begin
                if (cur_q > NF) begin
                    bin_d   = '0;
                    cur_d   = '0;
                    rise_d  = '0;
                    fall_d  = '0;
                    state_d = IDLE;
                end else if (cur_q == '0) begin
                    shift = 1'b1;
                end else begin
                    ret_d   = 1'b1;
                    state_d = EMIT;
                end
            end
            default: state_d = IDLE;
        endcase
        if (shift) begin
            fall_d = rise_q;
            rise_d = '0;
            cur_d  = cur_q + FW'(1);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            cur_q   <= '0;
            f_q     <= '0;
            w_q     <= '0;
            p_q     <= '0;
            last_q  <= 1'b0;
            ret_q   <= 1'b0;
            wcnt_q  <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            cur_q   <= cur_d;
            f_q     <= f_d;
            w_q     <= w_d;
            p_q     <= p_d;
            last_q  <= last_d;
            ret_q   <= ret_d;
            wcnt_q  <= wcnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end
endmodule
